// File: rtl/xbar_pkg.sv
// Shared crossbar constants and types for the W-channel dispatcher.
// The slave count lives here so index widths agree across every file.
package xbar_pkg;

  localparam int SLAVE_NUM = 3;
  localparam int SLV_IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  typedef enum logic [0:0] {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } w_disp_state_e;

  // Beat counters stick at 255 rather than wrapping on very long bursts.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/w_dispatch_if.sv
// Bundle of the dispatcher's route queue, W FIFO front and slave W-port signals.
// master = the dispatcher, slave = the surrounding crossbar / environment.
interface w_dispatch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
);
  import xbar_pkg::*;

  logic                   route_push;
  logic [SLV_IDX_W-1:0]   route_dst;
  logic                   route_full;

  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  front_WDATA;
  logic [STRB_WIDTH-1:0]  front_WSTRB;
  logic                   front_WLAST;
  logic                   fifo_pop;

  logic [DATA_WIDTH-1:0]  WDATA_S;
  logic [STRB_WIDTH-1:0]  WSTRB_S;
  logic                   WLAST_S;
  logic [SLAVE_NUM-1:0]   WVALID_S;
  logic [SLAVE_NUM-1:0]   WREADY_S;

  logic                   w_decerr;
  logic [7:0]             burst_beats;

  modport master (
    input  route_push, route_dst, fifo_empty, front_WDATA, front_WSTRB, front_WLAST, WREADY_S,
    output route_full, fifo_pop, WDATA_S, WSTRB_S, WLAST_S, WVALID_S, w_decerr, burst_beats
  );

  modport slave (
    output route_push, route_dst, fifo_empty, front_WDATA, front_WSTRB, front_WLAST, WREADY_S,
    input  route_full, fifo_pop, WDATA_S, WSTRB_S, WLAST_S, WVALID_S, w_decerr, burst_beats
  );

endinterface

// File: rtl/w_route_fifo.sv
// Count-based in-order queue of destination slave indices; every entry is usable.
// Exposes the head and the entry behind it so bursts can chain without a bubble.
module w_route_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         push,
  input  logic [W-1:0]                 push_dst,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head,
  output logic [W-1:0]                 next_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dst;
  end

  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign next_head = mem_q[rd_ptr_q + PTR_W'(1)];

endmodule

// File: rtl/w_dispatch.sv
// Steers W bursts from the per-master W FIFO to slave W ports in AW order.
// Bursts to a nonexistent slave are drained one beat per cycle and flagged.
module w_dispatch
  import xbar_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = 4,
  parameter int ROUTE_DEPTH = 4
) (
  input  logic         ACLK,
  input  logic         ARESET,
  w_dispatch_if.master bus
);

  localparam int CNT_W = $clog2(ROUTE_DEPTH + 1);

  w_disp_state_e        state_q, state_d;
  logic [SLV_IDX_W-1:0] cur_dst_q, cur_dst_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic [7:0]           burst_beats_q, burst_beats_d;

  logic                 rt_pop, rt_full, rt_empty;
  logic [CNT_W-1:0]     rt_count;
  logic [SLV_IDX_W-1:0] rt_head, rt_next;

  logic                 in_burst, dst_ok;
  logic                 handshake, drain, beat, last_beat;
  logic [SLAVE_NUM-1:0] wvalid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                 wlast;

  w_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .W     (SLV_IDX_W)
  ) u_route (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .push      (bus.route_push),
    .push_dst  (bus.route_dst),
    .pop       (rt_pop),
    .full      (rt_full),
    .empty     (rt_empty),
    .count     (rt_count),
    .head      (rt_head),
    .next_head (rt_next)
  );

  assign in_burst = (state_q == W_BURST);
  assign dst_ok   = ({1'b0, cur_dst_q} < (SLV_IDX_W + 1)'(SLAVE_NUM));

  // Valid follows FIFO occupancy; the front only moves on a pop, so it cannot drop early.
  generate
    for (genvar gi = 0; gi < SLAVE_NUM; gi++) begin : g_valid
      assign wvalid[gi] = in_burst & dst_ok & ~bus.fifo_empty & (cur_dst_q == SLV_IDX_W'(gi));
    end
  endgenerate

  assign handshake = |(wvalid & bus.WREADY_S);
  assign drain     = in_burst & ~dst_ok & ~bus.fifo_empty;
  assign beat      = handshake | drain;
  assign last_beat = beat & bus.front_WLAST;
  assign rt_pop    = last_beat;

  assign wdata = in_burst ? bus.front_WDATA : '0;
  assign wstrb = in_burst ? bus.front_WSTRB : '0;
  assign wlast = in_burst & bus.front_WLAST;

  always_comb begin
    state_d       = state_q;
    cur_dst_d     = cur_dst_q;
    beat_cnt_d    = beat_cnt_q;
    burst_beats_d = burst_beats_q;
    case (state_q)
      W_IDLE: begin
        if (!rt_empty) begin
          cur_dst_d = rt_head;
          state_d   = W_BURST;
        end
      end
      W_BURST: begin
        if (last_beat) begin
          beat_cnt_d    = '0;
          burst_beats_d = sat_inc8(beat_cnt_q);
          // Another burst already queued: switch straight to it with no idle cycle.
          if (rt_count > CNT_W'(1)) cur_dst_d = rt_next;
          else                      state_d   = W_IDLE;
        end else if (beat) begin
          beat_cnt_d = sat_inc8(beat_cnt_q);
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= W_IDLE;
      cur_dst_q     <= '0;
      beat_cnt_q    <= '0;
      burst_beats_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_dst_q     <= cur_dst_d;
      beat_cnt_q    <= beat_cnt_d;
      burst_beats_q <= burst_beats_d;
    end
  end

  assign bus.route_full  = rt_full;
  assign bus.fifo_pop    = beat;
  assign bus.WVALID_S    = wvalid;
  assign bus.WDATA_S     = wdata;
  assign bus.WSTRB_S     = wstrb;
  assign bus.WLAST_S     = wlast;
  assign bus.w_decerr    = drain & bus.front_WLAST;
  assign bus.burst_beats = burst_beats_q;

  a_valid_onehot0 : assert property (@(posedge ACLK) disable iff (ARESET) $onehot0(wvalid));

endmodule
